// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// EX forwarding select codes and the register-match helper used by every rule.
package hazard_ctrl_pkg;

  localparam int REGW = 5;
  typedef logic [REGW-1:0] regnum_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERROR   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REGFILE  = 2'b00;
  localparam logic [1:0] FWD_RESULT_W = 2'b01;
  localparam logic [1:0] FWD_ALUOUT_M = 2'b10;

  // $zero is never a real producer, so a match on register 0 never counts.
  function automatic logic reg_hit(input regnum_t src, input logic wr_en, input regnum_t dst);
    return wr_en && (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_e_sel(input regnum_t src,
                                           input logic rw_m, input regnum_t wr_m,
                                           input logic rw_w, input regnum_t wr_w);
    if (reg_hit(src, rw_m, wr_m)) return FWD_ALUOUT_M;
    if (reg_hit(src, rw_w, wr_w)) return FWD_RESULT_W;
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc_i high, sticks at all-ones,
// synchronous clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use / branch stalls,
// and a memory-wait FSM that freezes the pipe and latches a timeout error.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      Rs_D,
  input  logic [4:0]      Rt_D,
  input  logic [4:0]      Rs_E,
  input  logic [4:0]      Rt_E,
  input  logic [4:0]      WriteReg_E,
  input  logic [4:0]      WriteReg_M,
  input  logic [4:0]      WriteReg_W,
  input  logic            RegWrite_E,
  input  logic            RegWrite_M,
  input  logic            RegWrite_W,
  input  logic            MemtoReg_E,
  input  logic            MemtoReg_M,
  input  logic            Branch_D,
  input  logic            MemReq_M,
  input  logic            MemReady_M,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushE,
  output logic            FlushW,
  output logic            ForwardA_D,
  output logic            ForwardB_D,
  output logic [1:0]      ForwardA_E,
  output logic [1:0]      ForwardB_E,
  output logic            MemTimeout,
  output logic [CNTW-1:0] StallCycles
);

  localparam int WAITW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAITW-1:0] TIMEOUT_W = WAITW'(TIMEOUT);

  state_e           state_q;
  logic [WAITW-1:0] wait_cnt_q;
  logic             mem_timeout_q;

  logic memstall, lwstall, branchstall, hold_all;

  assign ForwardA_E = fwd_e_sel(Rs_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
  assign ForwardB_E = fwd_e_sel(Rt_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
  assign ForwardA_D = reg_hit(Rs_D, RegWrite_M, WriteReg_M);
  assign ForwardB_D = reg_hit(Rt_D, RegWrite_M, WriteReg_M);

  assign memstall    = MemReq_M && !MemReady_M;
  assign lwstall     = reg_hit(Rs_D, MemtoReg_E, WriteReg_E) || reg_hit(Rt_D, MemtoReg_E, WriteReg_E);
  assign branchstall = Branch_D &&
                       (reg_hit(Rs_D, RegWrite_E, WriteReg_E) || reg_hit(Rt_D, RegWrite_E, WriteReg_E) ||
                        reg_hit(Rs_D, MemtoReg_M, WriteReg_M) || reg_hit(Rt_D, MemtoReg_M, WriteReg_M));

  // While reset is asserted the FSM is treated as RUN, so ERROR cannot freeze the pipe.
  assign hold_all = memstall || ((state_q == ST_ERROR) && !reset);

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (hold_all) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lwstall || branchstall;
      StallD = lwstall || branchstall;
      FlushE = lwstall || branchstall;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (memstall) begin
            state_q    <= ST_MEMWAIT;
            wait_cnt_q <= WAITW'(1);
          end else begin
            wait_cnt_q <= '0;
          end
        end
        ST_MEMWAIT: begin
          // An acknowledge in the same cycle as the timeout still completes the access.
          if (MemReady_M) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == TIMEOUT_W) begin
            state_q       <= ST_ERROR;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_ERROR: begin
          state_q <= ST_ERROR;
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign MemTimeout = mem_timeout_q;

  sat_counter #(
    .WIDTH (CNTW)
  ) u_stall_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (StallF),
    .count_o (StallCycles)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max consecutive memory-wait cycles before error.
REQ-002 SHALL have parameter CNTW, default 16, width of stall-cycle counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports Rs_D, Rt_D, Rs_E, Rt_E  input  5 each  decode/execute source register numbers.
REQ-006 SHALL have ports WriteReg_E, WriteReg_M, WriteReg_W  input  5 each  destination registers per stage.
REQ-007 SHALL have ports RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M, Branch_D  input  1 each  stage control bits.
REQ-008 SHALL have ports MemReq_M  input  1  data-memory access in M; MemReady_M  input  1  memory ack, same cycle.
REQ-009 SHALL have ports StallF, StallD, StallE, StallM, FlushE, FlushW  output  1 each  pipeline register controls.
REQ-010 SHALL have ports ForwardA_D, ForwardB_D  output  1 each  ID equality-compare mux selects (ALUOut_M).
REQ-011 SHALL have ports ForwardA_E, ForwardB_E  output  2 each  EX operand selects: 00 regfile, 01 Result_W, 10 ALUOut_M.
REQ-012 SHALL have ports MemTimeout  output  1  sticky error; StallCycles  output  CNTW  saturating stall count.

Function
REQ-013 ForwardA_E SHALL be 10 if Rs_E!=0, RegWrite_M, Rs_E==WriteReg_M; else 01 if Rs_E!=0, RegWrite_W, Rs_E==WriteReg_W; else 00 (M priority); ForwardB_E likewise on Rt_E.
REQ-014 ForwardA_D SHALL be 1 iff Rs_D!=0, RegWrite_M, Rs_D==WriteReg_M; ForwardB_D likewise on Rt_D.
REQ-015 lwstall SHALL be MemtoReg_E and WriteReg_E!=0 and WriteReg_E equals Rs_D or Rt_D.
REQ-016 branchstall SHALL be Branch_D and ((RegWrite_E, WriteReg_E!=0, matches Rs_D/Rt_D) or (MemtoReg_M, WriteReg_M!=0, matches Rs_D/Rt_D)).
REQ-017 memstall SHALL be MemReq_M and not MemReady_M, combinational, zero-latency.
REQ-018 FSM states SHALL be RUN, MEMWAIT, ERROR.
REQ-019 RUN: memstall -> MEMWAIT, WaitCnt<=1; else stay, WaitCnt<=0.
REQ-020 MEMWAIT: MemReady_M=1 -> RUN, WaitCnt<=0; else if WaitCnt==TIMEOUT -> ERROR; else WaitCnt<=WaitCnt+1.
REQ-021 MemReady_M SHALL win over timeout when both occur in same cycle.
REQ-022 ERROR SHALL be absorbing until reset; MemTimeout=1 registered on entry.
REQ-023 When memstall=1 or state==ERROR: StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0.
REQ-024 Otherwise: StallF=StallD=FlushE=lwstall|branchstall; StallE=StallM=FlushW=0.
REQ-025 Forward outputs SHALL stay valid during all stalls.
REQ-026 StallCycles SHALL increment each cycle StallF=1, saturating at all-ones, never wrapping.

Reset
REQ-027 reset SHALL force state RUN, WaitCnt=0, MemTimeout=0, StallCycles=0 next edge, mid-wait or in ERROR.
REQ-028 Combinational outputs SHALL follow REQ-013..024 during reset, with state taken as RUN.

Structure
REQ-029 State encoding and ForwardX_E select codes (00/01/10) SHALL live in the shared pipeline package.
REQ-030 Saturating counter SHALL be sub-module sat_counter (parameter width, inc, clear, count).
REQ-031 Block SHALL be standalone beside ID; no datapath widths inside.

Verification
REQ-032 Rs_E=5, WriteReg_M=5, RegWrite_M=1, WriteReg_W=5, RegWrite_W=1 -> ForwardA_E=10; Rs_E=0 same setup -> 00.
REQ-033 MemtoReg_E=1, WriteReg_E=8, Rt_D=8 -> StallF=StallD=FlushE=1 one cycle, StallCycles 0->1.
REQ-034 Branch_D=1, Rs_D=3, RegWrite_E=1, WriteReg_E=3 -> stall; next cycle WriteReg_M=3, RegWrite_M=1, MemtoReg_M=0 -> no stall, ForwardA_D=1.
REQ-035 MemReq_M=1, MemReady_M=0 three cycles then 1 -> Stall F/D/E/M, FlushW high 3 cycles, FSM back to RUN, FlushE=0 throughout.
REQ-036 TIMEOUT=4, MemReady_M held 0 -> ERROR after 5 wait cycles, MemTimeout=1, stalls held; reset pulse -> RUN, outputs cleared.
REQ-037 StallF forced 1 with CNTW=4 for 20 cycles -> StallCycles holds 15.
